// File: rtl/controlador_jogo_if.sv
// Signal bundle between the battleship game controller and its surroundings.
// The slave modport is the controller's view; the master modport drives the controller.
interface controlador_jogo_if;
    logic [1:0] modo;
    logic       confirmar;
    logic       tick;
    logic [4:0] alvos_total;
    logic       resp_valida;
    logic       acerto;
    logic       repetido;

    logic [2:0] estado;
    logic       trava_mapa;
    logic       pedido_ataque;
    logic       hab_preparacao;
    logic       hab_ataque;
    logic       hab_matriz;
    logic [2:0] vida;
    logic [4:0] acertos;
    logic       vitoria;
    logic       derrota;

    modport slave (
        input  modo, confirmar, tick, alvos_total, resp_valida, acerto, repetido,
        output estado, trava_mapa, pedido_ataque, hab_preparacao, hab_ataque,
               hab_matriz, vida, acertos, vitoria, derrota
    );

    modport master (
        output modo, confirmar, tick, alvos_total, resp_valida, acerto, repetido,
        input  estado, trava_mapa, pedido_ataque, hab_preparacao, hab_ataque,
               hab_matriz, vida, acertos, vitoria, derrota
    );
endinterface

// File: rtl/controlador_jogo.sv
// Game controller FSM: map preparation, attack/evaluate loop, lives and hits bookkeeping.
// Optional per-shot timeout is compiled in with macro CONTROLADOR_JOGO_TIMEOUT_EN.
module controlador_jogo #(
    parameter int VIDAS_INI     = 3,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic                clock,
    input  logic                reset_n,
    controlador_jogo_if.slave   bus
);

    typedef enum logic [2:0] {
        DESLIGADO  = 3'd0,
        PREPARACAO = 3'd1,
        ATAQUE     = 3'd2,
        AVALIA     = 3'd3,
        VITORIA    = 3'd4,
        DERROTA    = 3'd5
    } estado_t;

    estado_t    r_estado;
    estado_t    w_prox;

    logic [2:0] r_vida;
    logic [4:0] r_acertos;
    logic       r_mapa_travado;
    logic       r_trava_mapa;
    logic       r_pedido_ataque;

    logic       w_carrega;
    logic       w_trava;
    logic       w_pedido;
    logic       w_inc_acerto;
    logic       w_perde_vida;
    logic       w_expira;
    logic [2:0] w_vida_menos;
    logic [4:0] w_acertos_mais;

    assign w_vida_menos   = (r_vida == 3'd0) ? 3'd0 : r_vida - 3'd1;
    assign w_acertos_mais = (r_acertos >= 5'd25) ? 5'd25 : r_acertos + 5'd1;

`ifdef CONTROLADOR_JOGO_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT_ULTIMO = 4'(TIMEOUT_TICKS - 1);

    logic [3:0] r_cnt_timeout;

    assign w_expira = (r_estado == ATAQUE) && bus.tick && (r_cnt_timeout == TIMEOUT_ULTIMO);

    // Counter restarts whenever ATAQUE is (re)entered, left, or has just expired.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt_timeout <= 4'd0;
        end else if ((r_estado != ATAQUE) || (w_prox != ATAQUE) || w_expira) begin
            r_cnt_timeout <= 4'd0;
        end else if (bus.tick) begin
            r_cnt_timeout <= r_cnt_timeout + 4'd1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_expira         = 1'b0;
    assign w_unused_timeout = bus.tick ^ TIMEOUT_TICKS[0];
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= DESLIGADO;
        end else begin
            r_estado <= w_prox;
        end
    end

    // An off mode outranks everything, so a confirm on the same edge is simply lost.
    always_comb begin
        w_prox       = r_estado;
        w_carrega    = 1'b0;
        w_trava      = 1'b0;
        w_pedido     = 1'b0;
        w_inc_acerto = 1'b0;
        w_perde_vida = 1'b0;
        if (bus.modo == 2'b00) begin
            w_prox = DESLIGADO;
        end else begin
            case (r_estado)
                DESLIGADO: begin
                    if (bus.modo == 2'b01) begin
                        w_prox    = PREPARACAO;
                        w_carrega = 1'b1;
                    end
                end
                PREPARACAO: begin
                    if (bus.modo[1] && r_mapa_travado && (bus.alvos_total != 5'd0)) begin
                        w_prox = ATAQUE;
                    end else if (bus.confirmar) begin
                        w_trava = 1'b1;
                    end
                end
                ATAQUE: begin
                    if (bus.confirmar) begin
                        w_prox   = AVALIA;
                        w_pedido = 1'b1;
                    end else if (w_expira) begin
                        w_perde_vida = 1'b1;
                        if (w_vida_menos == 3'd0) begin
                            w_prox = DERROTA;
                        end
                    end
                end
                AVALIA: begin
                    if (bus.resp_valida) begin
                        if (bus.repetido) begin
                            w_prox = ATAQUE;
                        end else if (bus.acerto) begin
                            w_inc_acerto = 1'b1;
                            w_prox = (w_acertos_mais == bus.alvos_total) ? VITORIA : ATAQUE;
                        end else begin
                            w_perde_vida = 1'b1;
                            w_prox = (w_vida_menos == 3'd0) ? DERROTA : ATAQUE;
                        end
                    end
                end
                VITORIA, DERROTA: begin
                    w_prox = r_estado;
                end
                default: begin
                    w_prox = DESLIGADO;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vida          <= 3'd0;
            r_acertos       <= 5'd0;
            r_mapa_travado  <= 1'b0;
            r_trava_mapa    <= 1'b0;
            r_pedido_ataque <= 1'b0;
        end else begin
            r_trava_mapa    <= w_trava;
            r_pedido_ataque <= w_pedido;
            if (w_carrega) begin
                r_vida    <= 3'(VIDAS_INI);
                r_acertos <= 5'd0;
            end else begin
                if (w_perde_vida) begin
                    r_vida <= w_vida_menos;
                end
                if (w_inc_acerto) begin
                    r_acertos <= w_acertos_mais;
                end
            end
            // The lock belongs to one game; leaving to DESLIGADO forgets it.
            if (r_estado == DESLIGADO) begin
                r_mapa_travado <= 1'b0;
            end else if (w_trava) begin
                r_mapa_travado <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.hab_preparacao = 1'b0;
        bus.hab_ataque     = 1'b0;
        bus.hab_matriz     = 1'b0;
        bus.vitoria        = 1'b0;
        bus.derrota        = 1'b0;
        case (r_estado)
            PREPARACAO: begin
                bus.hab_preparacao = 1'b1;
                bus.hab_matriz     = 1'b1;
            end
            ATAQUE, AVALIA: begin
                bus.hab_ataque = 1'b1;
                bus.hab_matriz = 1'b1;
            end
            VITORIA: bus.vitoria = 1'b1;
            DERROTA: bus.derrota = 1'b1;
            default: begin
                bus.hab_preparacao = 1'b0;
            end
        endcase
    end

    assign bus.estado        = r_estado;
    assign bus.trava_mapa    = r_trava_mapa;
    assign bus.pedido_ataque = r_pedido_ataque;
    assign bus.vida          = r_vida;
    assign bus.acertos       = r_acertos;

endmodule

// File: doc/controlador_jogo.md
CONTROLADOR_JOGO -- requirements
Module: controlador_jogo

Interface
REQ-001 Parameter VIDAS_INI, default 3, SHALL set the lives loaded at game start (1..7).
REQ-002 Parameter TIMEOUT_TICKS, default 10, SHALL set the tick count allowed per shot when timeout is compiled in (1..15).
REQ-003 Port clock, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-005 Port modo, input, 2, SHALL be the game mode switches {ch7,ch6}: 00 off, 01 preparation, 1x attack request.
REQ-006 Port confirmar, input, 1, SHALL be a one-cycle, active-high, debounced button pulse.
REQ-007 Port tick, input, 1, SHALL be a one-cycle timebase pulse used only by the timeout counter.
REQ-008 Port alvos_total, input, 5, SHALL be the ship-cell count of the locked map (0..25).
REQ-009 Ports resp_valida, acerto and repetido, inputs, 1 each, SHALL be the attack manager's result strobe, hit flag and already-fired flag.
REQ-010 Port estado, output, 3, SHALL expose the current FSM state encoding.
REQ-011 Ports trava_mapa and pedido_ataque, outputs, 1 each, SHALL be one-cycle command pulses.
REQ-012 Ports hab_preparacao, hab_ataque and hab_matriz, outputs, 1 each, SHALL be level enables.
REQ-013 Ports vida (3 bits) and acertos (5 bits), outputs, SHALL be the lives left and hits scored.
REQ-014 Ports vitoria and derrota, outputs, 1 each, SHALL be the end-of-game levels.

Function
REQ-015 The FSM SHALL use the states DESLIGADO=0, PREPARACAO=1, ATAQUE=2, AVALIA=3, VITORIA=4 and DERROTA=5.
REQ-016 When modo==00, the FSM SHALL enter DESLIGADO on the next edge from any state.
REQ-017 From DESLIGADO with modo==01, the FSM SHALL go to PREPARACAO, load vida=VIDAS_INI and clear acertos.
REQ-018 In PREPARACAO, confirmar SHALL pulse trava_mapa for one cycle, and the map SHALL be marked locked.
REQ-019 From PREPARACAO with modo[1]==1, the FSM SHALL move to ATAQUE only if the map is locked and alvos_total!=0; otherwise it SHALL stay in PREPARACAO.
REQ-020 In ATAQUE, confirmar SHALL assert pedido_ataque on the next cycle for exactly one cycle, and the FSM SHALL enter AVALIA.
REQ-021 AVALIA SHALL ignore confirmar and wait for resp_valida; there is no limit on the wait.
REQ-022 On resp_valida with repetido=1, the FSM SHALL return to ATAQUE with no counter change.
REQ-023 On resp_valida with acerto=1, acertos SHALL increment; when the new value equals alvos_total, the FSM SHALL go to VITORIA, otherwise back to ATAQUE.
REQ-024 On resp_valida with acerto=0, vida SHALL decrement; when the new value is 0, the FSM SHALL go to DERROTA, otherwise back to ATAQUE.
REQ-025 vida SHALL saturate at 0 and acertos SHALL saturate at 25; neither SHALL wrap.
REQ-026 VITORIA and DERROTA SHALL hold until modo==00; the vitoria and derrota outputs SHALL be high only in their own state.
REQ-027 hab_preparacao SHALL be high only in PREPARACAO.
REQ-028 hab_ataque SHALL be high in ATAQUE and in AVALIA.
REQ-029 hab_matriz SHALL be high in PREPARACAO, ATAQUE and AVALIA.
REQ-030 If confirmar and a modo change occur on the same edge, the mode transition SHALL win and the confirm SHALL be dropped.

Reset
REQ-031 reset_n low SHALL immediately force DESLIGADO, including mid-AVALIA or with a pulse pending.
REQ-032 During reset, all pulses and enables SHALL be 0, vida=0, acertos=0, the map SHALL be unlocked and the timeout counter SHALL be 0.

Configuration
REQ-033 With macro CONTROLADOR_JOGO_TIMEOUT_EN defined, a 4-bit counter SHALL clear on entering ATAQUE and count tick pulses while in ATAQUE.
REQ-034 With CONTROLADOR_JOGO_TIMEOUT_EN defined, reaching TIMEOUT_TICKS SHALL cost one life (vida-1, DERROTA at 0) and restart the counter.
REQ-035 Without CONTROLADOR_JOGO_TIMEOUT_EN, tick SHALL be ignored, and no timeout logic SHALL exist.

Verification
REQ-036 Reset, then modo=01, then confirmar -> vida=3, acertos=0, trava_mapa high for exactly 1 cycle, estado=1.
REQ-037 modo=10 before any confirmar -> estado stays 1; after confirmar with alvos_total=2 -> estado=2.
REQ-038 Two confirm/hit round trips with alvos_total=2 -> pedido_ataque pulses twice, acertos=2, estado=4, vitoria=1.
REQ-039 Three misses -> vida 3→2→1→0, estado=5, derrota=1; one repetido response -> vida unchanged.
REQ-040 reset_n pulled low while in AVALIA -> estado=0 asynchronously, all outputs 0; a late resp_valida is ignored.
REQ-041 With CONTROLADOR_JOGO_TIMEOUT_EN defined and TIMEOUT_TICKS=10, 10 ticks in ATAQUE -> vida decrements by 1 and estado stays 2.
